frame_tx: RTL and testbench

//  Transmit side of the variant string protocol. On a start request, emits the

---
 rtl/frame_tx.sv | 168 ++++++++++++++++
 tb/tb_frame_tx.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_tx.sv
// -----------------------------------------------------------------------------
// frame_tx
//   Transmit side of the variant string protocol. A start request latches two
//   operands and a math-symbol selector, then emits the frame
//     0x00 '{' <op_a hex> <symbol> <op_b hex> '}' 0x00
//   one byte at a time over a valid/ready byte stream.
//
// Parameters
//   HEX_DIGITS  hex characters per operand (operand width = 4*HEX_DIGITS)
//   LOWER_HEX   1: digits A-F sent as 'a'-'f'; 0: sent as 'A'-'F'
//
// Ports
//   clk       clock, all state on the rising edge
//   rst       asynchronous reset, active-low
//   start     frame request, accepted only while busy=0
//   op_a      first operand, latched on accepted start
//   op_b      second operand, latched on accepted start
//   op_sel    symbol select (+ - * / \ = < >), latched on accepted start
//   tx_data   current byte (registered)
//   tx_valid  tx_data holds a byte to transfer
//   tx_ready  sink accepts the byte; a transfer is tx_valid & tx_ready
//   busy      frame in progress
//   done      one-cycle pulse in the cycle after the final byte transfers
// -----------------------------------------------------------------------------
module frame_tx #(
  parameter int HEX_DIGITS = 4,
  parameter bit LOWER_HEX  = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [4*HEX_DIGITS-1:0] op_a,
  input  logic [4*HEX_DIGITS-1:0] op_b,
  input  logic [2:0]              op_sel,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    busy,
  output logic                    done
);

  localparam int             W      = 4 * HEX_DIGITS;
  localparam int             K_W    = (HEX_DIGITS > 1) ? $clog2(HEX_DIGITS) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(HEX_DIGITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SOF, S_OPEN, S_HEXA, S_OP, S_HEXB, S_CLOSE, S_EOF
  } state_t;

  state_t         state;
  logic [K_W-1:0] k;       // digit position within the current operand, 0 = MS
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [2:0]     sel_q;
  logic           xfer;

  // The only combinational use of tx_ready: it gates the advance, never data.
  assign xfer = tx_valid & tx_ready;

  // ASCII hex digit. Letters use (base - 10) so that n=10 maps to 'A'/'a'.
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return (LOWER_HEX ? 8'h57 : 8'h37) + {4'h0, n};
  endfunction

  // Nibble at digit position p counted from the most significant end.
  function automatic logic [3:0] nibble_ms(input logic [W-1:0]   v,
                                           input logic [K_W-1:0] p);
    logic [K_W-1:0] idx;
    logic [W-1:0]   s;
    idx = K_LAST - p;
    s   = v >> {idx, 2'b00};
    return s[3:0];
  endfunction

  function automatic logic [7:0] symbol(input logic [2:0] sel);
    case (sel)
      3'd0:    return 8'h2B;  // +
      3'd1:    return 8'h2D;  // -
      3'd2:    return 8'h2A;  // *
      3'd3:    return 8'h2F;  // /
      3'd4:    return 8'h5C;  // backslash
      3'd5:    return 8'h3D;  // =
      3'd6:    return 8'h3C;  // <
      default: return 8'h3E;  // >
    endcase
  endfunction

  // tx_data is loaded with the byte of the state being entered, so the byte
  // on the bus always belongs to the current state and stays put on a stall.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge value of every other register in this block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the operand registers are plain flops, so they are reset along
      // with the control state; a mid-frame reset drops the frame entirely.
      state    <= S_IDLE;
      k        <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= '0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_q      <= op_a;
            b_q      <= op_b;
            sel_q    <= op_sel;
            state    <= S_SOF;
            tx_data  <= 8'h00;
            tx_valid <= 1'b1;
            busy     <= 1'b1;
          end
        end
        S_SOF: if (xfer) begin
          state   <= S_OPEN;
          tx_data <= 8'h7B;
        end
        S_OPEN: if (xfer) begin
          state   <= S_HEXA;
          k       <= '0;
          tx_data <= hex_char(nibble_ms(a_q, '0));
        end
        S_HEXA: if (xfer) begin
          if (k == K_LAST) begin
            state   <= S_OP;
            tx_data <= symbol(sel_q);
          end else begin
            k       <= k + 1'b1;
            tx_data <= hex_char(nibble_ms(a_q, k + 1'b1));
          end
        end
        S_OP: if (xfer) begin
          state   <= S_HEXB;
          k       <= '0;
          tx_data <= hex_char(nibble_ms(b_q, '0));
        end
        S_HEXB: if (xfer) begin
          if (k == K_LAST) begin
            state   <= S_CLOSE;
            tx_data <= 8'h7D;
          end else begin
            k       <= k + 1'b1;
            tx_data <= hex_char(nibble_ms(b_q, k + 1'b1));
          end
        end
        S_CLOSE: if (xfer) begin
          state   <= S_EOF;
          tx_data <= 8'h00;
        end
        S_EOF: if (xfer) begin
          state    <= S_IDLE;
          tx_data  <= 8'h00;
          tx_valid <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_frame_tx
//   Drives two frame_tx instances (upper-case and lower-case hex) from shared
//   inputs and compares the byte streams against frames built from operand
//   text, plus a structural frame recogniser.
// -----------------------------------------------------------------------------
module tb_frame_tx;

  localparam int HD = 4;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [2:0]  op_sel;
  logic        tx_ready;

  logic [7:0]  tx_data_u, tx_data_l;
  logic        tx_valid_u, tx_valid_l;
  logic        busy_u, busy_l;
  logic        done_u, done_l;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_u[$];
  logic [7:0] exp_l[$];
  logic [7:0] got_u[$];
  logic [7:0] got_l[$];

  string syms = "+-*/\\=<>";

  frame_tx #(.HEX_DIGITS(HD), .LOWER_HEX(1'b0)) u_upper (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .op_sel(op_sel), .tx_data(tx_data_u), .tx_valid(tx_valid_u),
    .tx_ready(tx_ready), .busy(busy_u), .done(done_u)
  );

  frame_tx #(.HEX_DIGITS(HD), .LOWER_HEX(1'b1)) u_lower (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .op_sel(op_sel), .tx_data(tx_data_l), .tx_valid(tx_valid_l),
    .tx_ready(tx_ready), .busy(busy_l), .done(done_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- model
  // Frame as text: NUL '{' hex(a) symbol hex(b) '}' NUL.
  task automatic build_frames(input logic [15:0] a, input logic [15:0] b,
                              input logic [2:0] sel);
    string sa, sb;
    exp_u.delete();
    exp_l.delete();
    sa = $sformatf("%h", a);
    sb = $sformatf("%h", b);
    exp_l.push_back(8'h00); exp_l.push_back("{");
    for (int i = 0; i < sa.len(); i++) exp_l.push_back(sa[i]);
    exp_l.push_back(syms[sel]);
    for (int i = 0; i < sb.len(); i++) exp_l.push_back(sb[i]);
    exp_l.push_back("}"); exp_l.push_back(8'h00);
    sa = sa.toupper();
    sb = sb.toupper();
    exp_u.push_back(8'h00); exp_u.push_back("{");
    for (int i = 0; i < sa.len(); i++) exp_u.push_back(sa[i]);
    exp_u.push_back(syms[sel]);
    for (int i = 0; i < sb.len(); i++) exp_u.push_back(sb[i]);
    exp_u.push_back("}"); exp_u.push_back(8'h00);
  endtask

  function automatic bit is_hex(input logic [7:0] c);
    return (c >= "0" && c <= "9") || (c >= "A" && c <= "F") ||
           (c >= "a" && c <= "f");
  endfunction

  function automatic bit is_sym(input logic [7:0] c);
    for (int i = 0; i < syms.len(); i++) if (syms[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  // What the receiving recogniser accepts, expressed structurally.
  function automatic bit recognise(input logic [7:0] q[$]);
    int n;
    n = 2 * HD + 5;
    if (q.size() != n) return 1'b0;
    if (q[0] != 8'h00 || q[1] != "{" || q[n-2] != "}" || q[n-1] != 8'h00)
      return 1'b0;
    for (int i = 0; i < HD; i++)
      if (!is_hex(q[2+i]) || !is_hex(q[3+HD+i])) return 1'b0;
    return is_sym(q[2+HD]);
  endfunction

  // ---------------------------------------------------------------- helpers
  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] sel);
    op_a   = a;
    op_b   = b;
    op_sel = sel;
    start  = 1'b1;
  endtask

  task automatic compare_stream(input string name, input string which,
                                input logic [7:0] got[$], input logic [7:0] exp[$]);
    int bad;
    bad = -1;
    if (got.size() == exp.size()) begin
      for (int i = 0; i < exp.size(); i++)
        if (bad < 0 && got[i] !== exp[i]) bad = i;
    end else begin
      bad = 0;
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      if (got.size() != exp.size())
        $display("FAIL %s %s length: got %0d bytes, required %0d",
                 name, which, got.size(), exp.size());
      else
        $display("FAIL %s %s byte %0d: got %h, required %h",
                 name, which, bad, got[bad], exp[bad]);
    end
    checks++;
    if (!recognise(got)) begin
      errors++;
      $display("FAIL %s %s recognise: frame of %0d bytes rejected, required accepted",
               name, which, got.size());
    end
  endtask

  // Called at a negedge after start has been driven. Runs one frame to done.
  // ready_mode: 0 always ready, 1 toggle, 2 random. glitch_at: cycle in which
  // start is pulsed with different operands. chain: start next frame in done.
  task automatic collect(input string name, input logic [15:0] a,
                         input logic [15:0] b, input logic [2:0] sel,
                         input int ready_mode, input int glitch_at,
                         input bit chain, input logic [15:0] na,
                         input logic [15:0] nb, input logic [2:0] nsel);
    int         cyc;
    int         last_xfer;
    bit         seen_done;
    bit         stalled;
    logic [7:0] hold_u, hold_l;
    cyc = 0; last_xfer = -100; seen_done = 1'b0; stalled = 1'b0;
    hold_u = 8'h00; hold_l = 8'h00;
    build_frames(a, b, sel);
    got_u.delete();
    got_l.delete();
    while (!seen_done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == 1) begin
        checks++;
        if (tx_valid_u !== 1'b1 || tx_data_u !== 8'h00 || busy_u !== 1'b1) begin
          errors++;
          $display("FAIL %s first_byte: valid=%b data=%h busy=%b, required valid=1 data=00 busy=1",
                   name, tx_valid_u, tx_data_u, busy_u);
        end
      end
      if (done_u === 1'b1) begin
        seen_done = 1'b1;
        checks++;
        if (cyc != last_xfer + 1 || busy_u !== 1'b0 || tx_valid_u !== 1'b0 ||
            done_l !== 1'b1) begin
          errors++;
          $display("FAIL %s done_timing: done at cycle %0d busy=%b valid=%b done_l=%b, required cycle %0d busy=0 valid=0 done_l=1",
                   name, cyc, busy_u, tx_valid_u, done_l, last_xfer + 1);
        end
        if (chain) issue(na, nb, nsel);
      end else begin
        if (stalled) begin
          checks++;
          if (tx_valid_u !== 1'b1 || tx_valid_l !== 1'b1 ||
              tx_data_u !== hold_u || tx_data_l !== hold_l) begin
            errors++;
            $display("FAIL %s hold cycle %0d: valid=%b/%b data=%h/%h, required valid=1/1 data=%h/%h",
                     name, cyc, tx_valid_u, tx_valid_l, tx_data_u, tx_data_l,
                     hold_u, hold_l);
          end
        end
        if (cyc == glitch_at) begin
          op_a   = ~op_a;
          op_b   = ~op_b;
          op_sel = op_sel + 3'd1;
          start  = 1'b1;
        end
        case (ready_mode)
          0:       tx_ready = 1'b1;
          1:       tx_ready = cyc[0];
          default: tx_ready = 1'($urandom_range(0, 1));
        endcase
        if (tx_valid_u === 1'b1 && tx_ready) begin
          got_u.push_back(tx_data_u);
          last_xfer = cyc;
        end
        if (tx_valid_l === 1'b1 && tx_ready) got_l.push_back(tx_data_l);
        stalled = (tx_valid_u === 1'b1) && !tx_ready;
        hold_u  = tx_data_u;
        hold_l  = tx_data_l;
      end
    end
    if (!seen_done) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no done within 200 cycles, required done", name);
    end
    compare_stream(name, "upper", got_u, exp_u);
    compare_stream(name, "lower", got_l, exp_l);
  endtask

  // Expect a quiet, idle transmitter for n cycles.
  task automatic expect_idle(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++;
      if (tx_valid_u !== 1'b0 || busy_u !== 1'b0 || done_u !== 1'b0 ||
          tx_valid_l !== 1'b0 || busy_l !== 1'b0) begin
        errors++;
        $display("FAIL %s idle cycle %0d: valid=%b busy=%b done=%b, required 0 0 0",
                 name, i, tx_valid_u, busy_u, done_u);
      end
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b0; start = 1'b0; tx_ready = 1'b1;
    op_a = 16'h0; op_b = 16'h0; op_sel = 3'd0;
    #12;
    checks++;
    if (tx_data_u !== 8'h00 || tx_valid_u !== 1'b0 || busy_u !== 1'b0 ||
        done_u !== 1'b0 || tx_valid_l !== 1'b0 || busy_l !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: data=%h valid=%b busy=%b done=%b, required 00 0 0 0",
               tx_data_u, tx_valid_u, busy_u, done_u);
    end
    @(negedge clk);
    rst = 1'b1;
    expect_idle("after_reset", 3);
  endtask

  task automatic test_basic();
    issue(16'h1F3C, 16'hBEEF, 3'd0);
    collect("basic", 16'h1F3C, 16'hBEEF, 3'd0, 0, 0, 1'b0, 16'h0, 16'h0, 3'd0);
    expect_idle("basic_post", 2);
  endtask

  task automatic test_stall();
    issue(16'h1F3C, 16'hBEEF, 3'd0);
    collect("stall", 16'h1F3C, 16'hBEEF, 3'd0, 1, 0, 1'b0, 16'h0, 16'h0, 3'd0);
  endtask

  task automatic test_lower_hex();
    issue(16'h00AF, 16'hFFFF, 3'd7);
    collect("lower_hex", 16'h00AF, 16'hFFFF, 3'd7, 0, 0, 1'b0, 16'h0, 16'h0, 3'd0);
  endtask

  task automatic test_back_to_back();
    issue(16'h1234, 16'h9ABC, 3'd4);
    collect("busy_ignore", 16'h1234, 16'h9ABC, 3'd4, 0, 4, 1'b1,
            16'hCAFE, 16'h0D0E, 3'd5);
    collect("gapless", 16'hCAFE, 16'h0D0E, 3'd5, 0, 0, 1'b0, 16'h0, 16'h0, 3'd0);
  endtask

  task automatic test_reset_mid_frame();
    issue(16'h5A5A, 16'hA5A5, 3'd3);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      start    = 1'b0;
      tx_ready = 1'b1;
    end
    checks++;
    if (tx_valid_u !== 1'b1 || tx_data_u !== 8'h2F) begin
      errors++;
      $display("FAIL rst_mid_op_reached: valid=%b data=%h, required valid=1 data=2f",
               tx_valid_u, tx_data_u);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (tx_valid_u !== 1'b0 || busy_u !== 1'b0 || done_u !== 1'b0 ||
        tx_data_u !== 8'h00 || tx_valid_l !== 1'b0 || busy_l !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async: valid=%b busy=%b done=%b data=%h, required 0 0 0 00",
               tx_valid_u, busy_u, done_u, tx_data_u);
    end
    @(negedge clk);
    rst = 1'b1;
    expect_idle("rst_mid_release", 6);
  endtask

  task automatic test_random_loopback();
    logic [15:0] a, b;
    logic [2:0]  sel;
    for (int f = 0; f < 200; f++) begin
      a   = 16'($urandom);
      b   = 16'($urandom);
      sel = 3'($urandom_range(0, 7));
      issue(a, b, sel);
      collect($sformatf("random_%0d", f), a, b, sel, 2, 0, 1'b0,
              16'h0, 16'h0, 3'd0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_lower_hex();
    test_back_to_back();
    test_reset_mid_frame();
    test_random_loopback();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
